// File: rtl/gate_mux_bist_pkg.sv
// Shared encodings and named truth tables for the gate-from-mux BIST stage.
// Truth tables are indexed by {A,B}: bit[0]={0,0} ... bit[3]={1,1}.
package gate_mux_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/gate_mux_bist_if.sv
// Control/result bundle between the BIST stage and its surroundings.
// slave is the BIST side; master is the side that starts runs and returns Y.
interface gate_mux_bist_if;
  logic       start;
  logic       a_out;
  logic       b_out;
  logic       y_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  modport slave (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, err_count, fail_vec
  );

  modport master (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_mux_bist_settle_cnt.sv
// Settle-window counter: counts while enabled, terminal count at SETTLE_CYCLES-1.
module gate_mux_bist_settle_cnt #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam logic [3:0] TC_VAL = 4'(SETTLE_CYCLES - 1);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_cnt <= 4'd0;
    else if (i_en)
      r_cnt <= r_cnt + 4'd1;
  end

  assign o_tc = i_en && (r_cnt == TC_VAL);
endmodule

// File: rtl/gate_mux_bist.sv
// BIST for a 2-input mux-built gate: walks {A,B} through 00..11, checks Y vs TRUTH.
// state | meaning: IDLE idle/reset | DRIVE hold vector to settle | CHECK sample Y | DONE result held
module gate_mux_bist
  import gate_mux_bist_pkg::*;
#(
  parameter logic [3:0] TRUTH         = TT_OR,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  gate_mux_bist_if.slave bus
);
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("gate_mux_bist: SETTLE_CYCLES must be within 1..15");
  end

  state_t     r_state;
  logic [1:0] r_vec_idx;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err_count;
  logic [3:0] r_fail_vec;

  logic       w_settle_en;
  logic       w_settle_tc;
  logic       w_mismatch;

  assign w_settle_en = (r_state == ST_DRIVE);

  gate_mux_bist_settle_cnt #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk   (clk),
    .rst   (rst),
    .i_clr (!w_settle_en),
    .i_en  (w_settle_en),
    .o_tc  (w_settle_tc)
  );

  // Case inequality so an X on Y during CHECK is scored as a mismatch in simulation.
  assign w_mismatch = (bus.y_in !== TRUTH[r_vec_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vec_idx   <= 2'd0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= 3'd0;
      r_fail_vec  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state     <= ST_DRIVE;
            r_vec_idx   <= 2'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 3'd0;
            r_fail_vec  <= 4'd0;
          end
        end
        ST_DRIVE: begin
          if (w_settle_tc)
            r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            r_fail_vec[r_vec_idx] <= 1'b1;
            r_err_count           <= r_err_count + 3'd1;
          end
          if (r_vec_idx == 2'd3) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err_count == 3'd0) && !w_mismatch;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
          end else begin
            r_state    <= ST_DRIVE;
            r_vec_idx  <= r_vec_idx + 2'd1;
            {r_a, r_b} <= r_vec_idx + 2'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.a_out     = r_a;
  assign bus.b_out     = r_b;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err_count;
  assign bus.fail_vec  = r_fail_vec;
endmodule

// File: tb/tb_gate_mux_bist.sv
// Directed bench for gate_mux_bist: an OR instance (SETTLE=2) and an AND instance (SETTLE=1).
// Expected run results come from behavioural gate models and are checked when done rises.
module tb_gate_mux_bist;
  import gate_mux_bist_pkg::*;

  typedef struct {
    logic [2:0] err;
    logic [3:0] fv;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  int   mode_or  = 0;  // 0 correct OR, 1 stuck-at-0
  int   mode_and = 0;  // 0 correct AND, 2 OR substituted
  exp_t sb_q[$];

  always #5 clk = ~clk;

  gate_mux_bist_if if_or ();
  gate_mux_bist_if if_and ();

  function automatic logic or_mux(input logic a, input logic b);
    return a ? 1'b1 : b;
  endfunction

  function automatic logic and_mux(input logic a, input logic b);
    return a ? b : 1'b0;
  endfunction

  function automatic logic gate_model(input int sel, input int mode, input logic a, input logic b);
    if (sel == 0) return (mode == 1) ? 1'b0 : or_mux(a, b);
    return (mode == 2) ? or_mux(a, b) : and_mux(a, b);
  endfunction

  assign if_or.y_in  = gate_model(0, mode_or, if_or.a_out, if_or.b_out);
  assign if_and.y_in = gate_model(1, mode_and, if_and.a_out, if_and.b_out);

  gate_mux_bist #(.TRUTH(TT_OR), .SETTLE_CYCLES(2)) dut_or (
    .clk (clk),
    .rst (rst),
    .bus (if_or)
  );

  gate_mux_bist #(.TRUTH(TT_AND), .SETTLE_CYCLES(1)) dut_and (
    .clk (clk),
    .rst (rst),
    .bus (if_and)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) if_or.start = v;
    else          if_and.start = v;
  endtask

  task automatic rd(input int sel, output logic [1:0] ab, output logic busy, output logic done,
                    output logic pass, output logic [2:0] err, output logic [3:0] fv);
    if (sel == 0) begin
      ab = {if_or.a_out, if_or.b_out}; busy = if_or.busy; done = if_or.done;
      pass = if_or.pass; err = if_or.err_count; fv = if_or.fail_vec;
    end else begin
      ab = {if_and.a_out, if_and.b_out}; busy = if_and.busy; done = if_and.done;
      pass = if_and.pass; err = if_and.err_count; fv = if_and.fail_vec;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input int sel, input string tag);
    logic [1:0] ab; logic busy, done, pass; logic [2:0] err; logic [3:0] fv;
    rd(sel, ab, busy, done, pass, err, fv);
    chk({tag, "_ab"},   8'(ab),   8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_done"}, 8'(done), 8'd0);
    chk({tag, "_pass"}, 8'(pass), 8'd0);
    chk({tag, "_err"},  8'(err),  8'd0);
    chk({tag, "_fv"},   8'(fv),   8'd0);
  endtask

  // Pushes the model's expected result, runs one test, and pops/compares when done rises.
  task automatic do_run(input int sel, input int s, input bit pulse_mid, input string tag);
    exp_t       e_exp;
    exp_t       e_got;
    logic [3:0] tt;
    logic [1:0] ab; logic busy, done, pass; logic [2:0] err; logic [3:0] fv;
    int         mode;
    int         n_edges;
    tt   = (sel == 0) ? TT_OR : TT_AND;
    mode = (sel == 0) ? mode_or : mode_and;
    e_exp.err = 3'd0;
    e_exp.fv  = 4'd0;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] vv;
      vv = 2'(v);
      if (gate_model(sel, mode, vv[1], vv[0]) !== tt[v]) begin
        e_exp.fv[v] = 1'b1;
        e_exp.err   = e_exp.err + 3'd1;
      end
    end
    e_exp.pass = (e_exp.err == 3'd0);
    sb_q.push_back(e_exp);

    n_edges = 4 * (s + 1);
    set_start(sel, 1'b1);
    for (int e = 0; e < n_edges; e++) begin
      tick();
      set_start(sel, pulse_mid && (e == 1 || e == 5));
      rd(sel, ab, busy, done, pass, err, fv);
      chk($sformatf("%s_ab_e%0d", tag, e),   8'(ab),   8'(e / (s + 1)));
      chk($sformatf("%s_busy_e%0d", tag, e), 8'(busy), 8'd1);
      chk($sformatf("%s_done_e%0d", tag, e), 8'(done), 8'd0);
      if (e == 0) begin
        chk({tag, "_err_clr"}, 8'(err), 8'd0);
        chk({tag, "_fv_clr"},  8'(fv),  8'd0);
      end
    end
    tick();
    set_start(sel, 1'b0);
    rd(sel, ab, busy, done, pass, err, fv);
    chk({tag, "_done"},      8'(done), 8'd1);
    chk({tag, "_busy_end"},  8'(busy), 8'd0);
    chk({tag, "_ab_end"},    8'(ab),   8'd0);
    if (done === 1'b1 && sb_q.size() > 0) begin
      e_got = sb_q.pop_front();
      chk({tag, "_err"},  8'(err),  8'(e_got.err));
      chk({tag, "_fv"},   8'(fv),   8'(e_got.fv));
      chk({tag, "_pass"}, 8'(pass), 8'(e_got.pass));
    end else begin
      chk({tag, "_done_timeout"}, 8'(done), 8'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
  endtask

  initial begin
    logic [1:0] ab; logic busy, done, pass; logic [2:0] err; logic [3:0] fv;
    if_or.start  = 1'b0;
    if_and.start = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk_idle(0, "rst_or");
    chk_idle(1, "rst_and");
    rst = 1'b0;
    tick();

    do_run(0, 2, 1'b0, "or_good");
    tick();
    tick();
    rd(0, ab, busy, done, pass, err, fv);
    chk("or_done_hold", 8'(done), 8'd1);
    chk("or_pass_hold", 8'(pass), 8'd1);

    do_run(0, 2, 1'b1, "or_repulse");

    mode_or = 1;
    do_run(0, 2, 1'b0, "or_stuck0");
    mode_or = 0;
    do_run(0, 2, 1'b0, "or_after_fail");

    do_run(1, 1, 1'b0, "and_good");
    mode_and = 2;
    do_run(1, 1, 1'b0, "and_or_sub");
    mode_and = 0;

    // Abort during vector-2 settle, then confirm nothing restarts on its own.
    set_start(0, 1'b1);
    for (int e = 0; e < 7; e++) begin
      tick();
      set_start(0, 1'b0);
    end
    rd(0, ab, busy, done, pass, err, fv);
    chk("abort_pre_ab",   8'(ab),   8'd2);
    chk("abort_pre_busy", 8'(busy), 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle(0, "abort");
    for (int i = 0; i < 5; i++) begin
      tick();
      rd(0, ab, busy, done, pass, err, fv);
      chk($sformatf("abort_done_low_%0d", i), 8'(done), 8'd0);
      chk($sformatf("abort_busy_low_%0d", i), 8'(busy), 8'd0);
    end
    do_run(0, 2, 1'b0, "or_post_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
